// File: rtl/alu_muldiv_if.sv
// Request/response bundle for the iterative RV32M multiply/divide unit.
// The master side issues operations and consumes results. The slave side is the unit itself.
interface alu_muldiv_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_funct3;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_funct3, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_funct3, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Define ALU_MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle multiplier.
module alu_muldiv #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    alu_muldiv_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [XLEN-1:0]    opB_q, opB_d;
    logic [2*XLEN-1:0]  prod_q, prod_d;
    logic               negQ_q, negQ_d;
    logic               negR_q, negR_d;
    logic [XLEN-1:0]    result_q, result_d;

    logic               signedA, signedB, aNeg, bNeg;
    logic [XLEN-1:0]    magA, magB;
    logic               isDiv, divZero, divOverflow;
    logic [XLEN:0]      mulSum, divShift, divDiff;
    logic [2*XLEN-1:0]  mulNext, divNext, stepNext, prodFix;
    logic [XLEN-1:0]    quoFix, remFix, finalResult;

    // Operand decode at accept: sign flags and magnitudes for the chosen signedness.
    always_comb begin
        signedA     = (bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b010) ||
                      (bus.in_funct3 == 3'b100) || (bus.in_funct3 == 3'b110);
        signedB     = (bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b100) ||
                      (bus.in_funct3 == 3'b110);
        aNeg        = signedA && bus.in_a[XLEN-1];
        bNeg        = signedB && bus.in_b[XLEN-1];
        magA        = aNeg ? -bus.in_a : bus.in_a;
        magB        = bNeg ? -bus.in_b : bus.in_b;
        isDiv       = bus.in_funct3[2];
        divZero     = (bus.in_b == '0);
        divOverflow = signedB && isDiv &&
                      (bus.in_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.in_b == '1);
    end

    // prod_q holds {accumulator, multiplier} for multiply and {remainder, quotient} for divide.
    always_comb begin
        mulSum   = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                   (prod_q[0] ? {1'b0, opB_q} : {(XLEN+1){1'b0}});
        mulNext  = {mulSum, prod_q[XLEN-1:1]};
        divShift = prod_q[2*XLEN-1:XLEN-1];
        divDiff  = divShift - {1'b0, opB_q};
        divNext  = divDiff[XLEN] ? {divShift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0}
                                 : {divDiff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
        stepNext = funct3_q[2] ? divNext : mulNext;
    end

    always_comb begin
        prodFix     = negQ_q ? -stepNext : stepNext;
        quoFix      = negQ_q ? -stepNext[XLEN-1:0] : stepNext[XLEN-1:0];
        remFix      = negR_q ? -stepNext[2*XLEN-1:XLEN] : stepNext[2*XLEN-1:XLEN];
        finalResult = remFix;
        case (funct3_q)
            3'b000:                 finalResult = prodFix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: finalResult = prodFix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         finalResult = quoFix;
            default:                finalResult = remFix;
        endcase
    end

`ifdef ALU_MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fastProd;

    always_comb begin
        fastProd = {{XLEN{aNeg}}, bus.in_a} * {{XLEN{bNeg}}, bus.in_b};
    end
`endif

    assign bus.in_ready   = (state_q == IDLE) && !flush;
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_result = result_q;
    assign bus.out_tag    = tag_q;

    // Flush wins over everything, including a same-cycle request or result handshake.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        funct3_d = funct3_q;
        tag_d    = tag_q;
        opB_d    = opB_q;
        prod_d   = prod_q;
        negQ_d   = negQ_q;
        negR_d   = negR_q;
        result_d = result_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        funct3_d = bus.in_funct3;
                        tag_d    = bus.in_tag;
                        opB_d    = magB;
                        prod_d   = {{XLEN{1'b0}}, magA};
                        negQ_d   = aNeg ^ bNeg;
                        negR_d   = aNeg;
                        count_d  = CNT_W'(XLEN - 1);
                        state_d  = BUSY;
                        if (isDiv && divZero) begin
                            result_d = bus.in_funct3[1] ? bus.in_a : '1;
                            state_d  = DONE;
                        end else if (divOverflow) begin
                            result_d = bus.in_funct3[1] ? '0 : bus.in_a;
                            state_d  = DONE;
`ifdef ALU_MULDIV_FAST_MUL_EN
                        end else if (!isDiv) begin
                            result_d = (bus.in_funct3 == 3'b000) ? fastProd[XLEN-1:0]
                                                                 : fastProd[2*XLEN-1:XLEN];
                            state_d  = DONE;
`endif
                        end
                    end
                end
                BUSY: begin
                    prod_d = stepNext;
                    if (count_q == '0) begin
                        result_d = finalResult;
                        state_d  = DONE;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            funct3_q <= '0;
            tag_q    <= '0;
            opB_q    <= '0;
            prod_q   <= '0;
            negQ_q   <= 1'b0;
            negR_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            funct3_q <= funct3_d;
            tag_q    <= tag_d;
            opB_q    <= opB_d;
            prod_q   <= prod_d;
            negQ_q   <= negQ_d;
            negR_q   <= negR_d;
            result_q <= result_d;
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: RV32M results, latencies, special cases, hold, flush and reset.
// Expected multiply latency follows ALU_MULDIV_FAST_MUL_EN when that macro is defined.
module tb_alu_muldiv;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
`ifdef ALU_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif
    localparam int DIV_LAT = XLEN + 1;

    typedef struct {
        logic [2:0]       f;
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  exp;
        int               lat;
    } vec_t;

    logic clk;
    logic rst_n;
    logic flush;
    int   cycle  = 0;
    int   checks = 0;
    int   errors = 0;

    alu_muldiv_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    alu_muldiv #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    // Present one request for a single rising edge; acc is the cycle number of that edge.
    task automatic applyStimulus(input logic [2:0] f, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag,
                                 output int acc);
        bus.in_valid  = 1'b1;
        bus.in_funct3 = f;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_tag    = tag;
        @(posedge clk);
        #1;
        acc          = cycle;
        bus.in_valid = 1'b0;
    endtask

    // Issue, wait (bounded) for the result, capture it, and let the handshake complete.
    task automatic runOp(input logic [2:0] f, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag,
                         output logic [XLEN-1:0] res, output logic [TAG_W-1:0] otag,
                         output int lat, output int acc);
        applyStimulus(f, a, b, tag, acc);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.out_valid !== 1'b1 && lat < 100);
        res  = bus.out_result;
        otag = bus.out_tag;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_funct3 = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        checks++;
        if (bus.out_result !== '0) begin
            errors++;
            $display("[TB] FAIL reset_out_result: got %h expected 0", bus.out_result);
        end
        checks++;
        if (bus.out_tag !== '0) begin
            errors++;
            $display("[TB] FAIL reset_out_tag: got %h expected 0", bus.out_tag);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_mul();
        vec_t             v[5];
        logic [XLEN-1:0]  res;
        logic [TAG_W-1:0] otag;
        int               lat, acc;
        v[0] = '{3'b000, 32'd7,         32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, MUL_LAT};
        v[1] = '{3'b001, 32'h80000000,  32'h80000000, 5'd6,  32'h40000000, MUL_LAT};
        v[2] = '{3'b010, 32'hFFFFFFFF,  32'hFFFFFFFF, 5'd7,  32'hFFFFFFFF, MUL_LAT};
        v[3] = '{3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF, 5'd8,  32'hFFFFFFFE, MUL_LAT};
        v[4] = '{3'b001, 32'd3,         32'hFFFFFFFE, 5'd9,  32'hFFFFFFFF, MUL_LAT};
        foreach (v[i]) begin
            runOp(v[i].f, v[i].a, v[i].b, v[i].tag, res, otag, lat, acc);
            checks++;
            if (res !== v[i].exp) begin
                errors++;
                $display("[TB] FAIL mul_result[%0d]: got %h expected %h", i, res, v[i].exp);
            end
            checks++;
            if (otag !== v[i].tag) begin
                errors++;
                $display("[TB] FAIL mul_tag[%0d]: got %0d expected %0d", i, otag, v[i].tag);
            end
            checks++;
            if (lat !== v[i].lat) begin
                errors++;
                $display("[TB] FAIL mul_latency[%0d]: got %0d expected %0d", i, lat, v[i].lat);
            end
        end
    endtask

    task automatic test_div();
        vec_t             v[6];
        logic [XLEN-1:0]  res;
        logic [TAG_W-1:0] otag;
        int               lat, acc;
        v[0] = '{3'b100, 32'hFFFFFFEC, 32'd3,        5'd10, 32'hFFFFFFFA, DIV_LAT};
        v[1] = '{3'b110, 32'hFFFFFFEC, 32'd3,        5'd11, 32'hFFFFFFFE, DIV_LAT};
        v[2] = '{3'b101, 32'hFFFFFFFF, 32'd2,        5'd12, 32'h7FFFFFFF, DIV_LAT};
        v[3] = '{3'b111, 32'd100,      32'd7,        5'd13, 32'd2,        DIV_LAT};
        v[4] = '{3'b100, 32'd20,       32'hFFFFFFFD, 5'd14, 32'hFFFFFFFA, DIV_LAT};
        v[5] = '{3'b110, 32'd20,       32'hFFFFFFFD, 5'd15, 32'd2,        DIV_LAT};
        foreach (v[i]) begin
            runOp(v[i].f, v[i].a, v[i].b, v[i].tag, res, otag, lat, acc);
            checks++;
            if (res !== v[i].exp) begin
                errors++;
                $display("[TB] FAIL div_result[%0d]: got %h expected %h", i, res, v[i].exp);
            end
            checks++;
            if (otag !== v[i].tag) begin
                errors++;
                $display("[TB] FAIL div_tag[%0d]: got %0d expected %0d", i, otag, v[i].tag);
            end
            checks++;
            if (lat !== v[i].lat) begin
                errors++;
                $display("[TB] FAIL div_latency[%0d]: got %0d expected %0d", i, lat, v[i].lat);
            end
        end
    endtask

    task automatic test_special();
        vec_t             v[6];
        logic [XLEN-1:0]  res;
        logic [TAG_W-1:0] otag;
        int               lat, acc;
        v[0] = '{3'b100, 32'd5,        32'd0,        5'd16, 32'hFFFFFFFF, 1};
        v[1] = '{3'b111, 32'd5,        32'd0,        5'd17, 32'd5,        1};
        v[2] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000, 1};
        v[3] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'd0,        1};
        v[4] = '{3'b101, 32'd5,        32'd0,        5'd20, 32'hFFFFFFFF, 1};
        v[5] = '{3'b110, 32'hFFFFFFF9, 32'd0,        5'd21, 32'hFFFFFFF9, 1};
        foreach (v[i]) begin
            runOp(v[i].f, v[i].a, v[i].b, v[i].tag, res, otag, lat, acc);
            checks++;
            if (res !== v[i].exp) begin
                errors++;
                $display("[TB] FAIL special_result[%0d]: got %h expected %h", i, res, v[i].exp);
            end
            checks++;
            if (otag !== v[i].tag) begin
                errors++;
                $display("[TB] FAIL special_tag[%0d]: got %0d expected %0d", i, otag, v[i].tag);
            end
            checks++;
            if (lat !== v[i].lat) begin
                errors++;
                $display("[TB] FAIL special_latency[%0d]: got %0d expected %0d", i, lat, v[i].lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0]  res;
        logic [TAG_W-1:0] otag;
        int               lat, acc0, acc1;
        runOp(3'b101, 32'h80000000, 32'h10, 5'd22, res, otag, lat, acc0);
        checks++;
        if (res !== 32'h08000000) begin
            errors++;
            $display("[TB] FAIL b2b_first_result: got %h expected 08000000", res);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_in_ready_after_handshake: got %b expected 1", bus.in_ready);
        end
        runOp(3'b110, 32'd7, 32'hFFFFFFFE, 5'd23, res, otag, lat, acc1);
        checks++;
        if (res !== 32'd1) begin
            errors++;
            $display("[TB] FAIL b2b_second_result: got %h expected 00000001", res);
        end
        checks++;
        if (otag !== 5'd23) begin
            errors++;
            $display("[TB] FAIL b2b_second_tag: got %0d expected 23", otag);
        end
        checks++;
        if (acc1 - acc0 !== XLEN + 2) begin
            errors++;
            $display("[TB] FAIL b2b_spacing: got %0d expected %0d", acc1 - acc0, XLEN + 2);
        end
    endtask

    task automatic test_hold();
        int lat, acc;
        bus.out_ready = 1'b0;
        applyStimulus(3'b111, 32'd100, 32'd7, 5'd9, acc);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.out_valid !== 1'b1 && lat < 100);
        checks++;
        if (lat !== DIV_LAT) begin
            errors++;
            $display("[TB] FAIL hold_latency: got %0d expected %0d", lat, DIV_LAT);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd2 ||
                bus.out_tag !== 5'd9 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold_stable[%0d]: got v=%b r=%h t=%0d rdy=%b expected v=1 r=2 t=9 rdy=0",
                         i, bus.out_valid, bus.out_result, bus.out_tag, bus.in_ready);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_release: got v=%b rdy=%b expected v=0 rdy=1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_flush();
        logic [XLEN-1:0]  res;
        logic [TAG_W-1:0] otag;
        int               lat, acc, seen;
        applyStimulus(3'b101, 32'd1000, 32'd7, 5'd24, acc);
        repeat (10) @(negedge clk);
        flush         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_funct3 = 3'b000;
        bus.in_a      = 32'd2;
        bus.in_b      = 32'd3;
        bus.in_tag    = 5'd25;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_in_ready: got %b expected 0", bus.in_ready);
        end
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_idle: got v=%b rdy=%b expected v=0 rdy=1",
                     bus.out_valid, bus.in_ready);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("[TB] FAIL flush_no_result: got %0d valid cycles expected 0", seen);
        end
        runOp(3'b101, 32'd9, 32'd3, 5'd3, res, otag, lat, acc);
        checks++;
        if (res !== 32'd3 || otag !== 5'd3 || lat !== DIV_LAT) begin
            errors++;
            $display("[TB] FAIL flush_followup: got r=%h t=%0d lat=%0d expected r=3 t=3 lat=%0d",
                     res, otag, lat, DIV_LAT);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [XLEN-1:0]  res;
        logic [TAG_W-1:0] otag;
        int               lat, acc, seen;
        applyStimulus(3'b100, 32'hFFFFFFEC, 32'd3, 5'd14, acc);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_result !== '0 || bus.out_tag !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got v=%b r=%h t=%0d expected v=0 r=0 t=0",
                     bus.out_valid, bus.out_result, bus.out_tag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_in_ready: got %b expected 1", bus.in_ready);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("[TB] FAIL midreset_no_result: got %0d valid cycles expected 0", seen);
        end
        runOp(3'b000, 32'h12345678, 32'h10, 5'd1, res, otag, lat, acc);
        checks++;
        if (res !== 32'h23456780 || otag !== 5'd1 || lat !== MUL_LAT) begin
            errors++;
            $display("[TB] FAIL midreset_followup: got r=%h t=%0d lat=%0d expected r=23456780 t=1 lat=%0d",
                     res, otag, lat, MUL_LAT);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_back_to_back();
        test_hold();
        test_flush();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the pipelined core. It sits beside the single-cycle ALU in the execute stage. It accepts one operation at a time through a valid/ready handshake and returns the result with a destination tag after a multi-cycle computation. A flush input lets the pipeline discard an in-flight operation on a branch mispredict or trap.

## Interface
- `XLEN`, 32: operand/result width; must be even, ≥ 8.
- `TAG_W`, 5: width of the pass-through tag (destination register index).
- `clk`  input  1  clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `flush`  input  1  abort any operation; no result is produced.
- `in_valid`  input  1  request valid.
- `in_ready`  output  1  unit can accept a request.
- `in_funct3`  input  3  RV32M funct3 (000 MUL … 111 REMU).
- `in_a`  input  XLEN  rs1 operand.
- `in_b`  input  XLEN  rs2 operand.
- `in_tag`  input  TAG_W  tag returned with the result.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  consumer accepts result.
- `out_result`  output  XLEN  result.
- `out_tag`  output  TAG_W  tag of the result.

## Operation
- FSM states: IDLE, BUSY, DONE.
- `in_ready` = (state == IDLE) && !flush.
- Accept = `in_valid && in_ready`. On accept, latch funct3, tag and operand magnitudes plus sign flags, then go to BUSY. Signedness: MULH/DIV/REM treat both operands as signed; MULHSU treats a as signed and b as unsigned; the others are unsigned.
- BUSY, multiply: shift-add, one bit per cycle, with a 2·XLEN product register. The iteration counter runs XLEN-1 down to 0.
- BUSY, divide: restoring division, one quotient bit per cycle on magnitudes. Sign fix-up in DONE entry: quotient negated if the operand signs differ; remainder takes the sign of the dividend.
- Result select: MUL → low XLEN bits; MULH/MULHSU/MULHU → high XLEN bits of the correctly signed 2·XLEN product.
- Special cases are detected at accept; the unit goes directly to DONE:
  - divide by zero: DIV/DIVU → all ones; REM/REMU → `in_a`.
  - signed overflow (a = −2^(XLEN−1), b = −1): DIV → `in_a`; REM → 0.
- DONE: `out_valid`=1 and `out_result`/`out_tag` held stable until `out_valid && out_ready`, then the FSM returns to IDLE.
- `flush` (any state): next state IDLE, `out_valid` drops next cycle, no acceptance that cycle. Flush overrides in_valid and out_ready in the same cycle.
- Reset: state IDLE, counter 0, `out_valid`=0, `out_result`=0, `out_tag`=0; `in_ready`=1 once reset is released.

## Timing
- Acceptance at edge E0.
- Iterative op: BUSY for XLEN cycles; `out_valid` is high from edge E0+XLEN+1, i.e. 33 cycles for XLEN=32.
- Special-case divide: `out_valid` from E0+1.
- The handshake completes on the edge where `out_valid && out_ready`. `in_ready` rises the following cycle, so back-to-back throughput is one op per XLEN+2 cycles.
- `out_valid` and `in_ready` are never high in the same cycle.
- Reset assertion mid-operation clears everything asynchronously; no result is emitted.

## Configuration
- `ALU_MULDIV_FAST_MUL_EN` defined: all four multiply ops use a single-cycle combinational 2·XLEN multiply and go from accept straight to DONE, with `out_valid` at E0+1. Divide timing is unchanged.
- Not defined: multiplies use the iterative XLEN-cycle path above. No combinational multiplier is synthesised.

## Test plan
- MUL a=7, b=−3 (0xFFFFFFFD), tag=5 → out_result 0xFFFFFFEB, out_tag 5, out_valid at E0+33 (E0+1 with FAST_MUL).
- MULH a=0x80000000, b=0x80000000 → 0x40000000; MULHSU a=−1, b=0xFFFFFFFF → 0xFFFFFFFF; MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE.
- DIV −20/3 → −6 (0xFFFFFFFA); REM −20/3 → −2; DIVU 0xFFFFFFFF/2 → 0x7FFFFFFF; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/−1 → 0x80000000; REM of the same → 0. All valid at E0+1.
- Hold out_ready=0 for 10 cycles in DONE → out_result/out_tag stable, in_ready=0; then out_ready=1 → in_ready=1 the next cycle.
- Flush at BUSY cycle 10, with in_valid high in the same cycle → no out_valid, no acceptance, IDLE next cycle. A following DIVU 9/3 → 3. Repeat with rst_n pulsed low mid-BUSY → outputs at reset values immediately.
